ss_scan_ctrl: RTL and testbench
===============================

// Module: ss_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for the seven-segment display path.
//  - Holds a 32-bit value and presents one hex nibble per digit slot to the shared decoder.
//  - Drives the active-low digit enables for an NUM_DIGITS-digit common-anode display.
//  - Updates the shown value only at frame boundaries, so a frame never mixes two values.
//  - Inserts a blanking gap before each digit to suppress ghosting.
// PARAMETERS
//  NUM_DIGITS    8      digits scanned per frame (1..8); digit k shows value[4k+3:4k]
//  SLOT_CYCLES   50000  clk cycles per digit slot; must be > BLANK_CYCLES
//  BLANK_CYCLES  64     cycles at start of each slot with all digits off (>=1)
// PORTS
//  clk          in   1           system clock
//  rst          in   1           synchronous reset, active-high
//  wr_en        in   1           write strobe for wr_data (single-cycle, no backpressure)
//  wr_data      in   32          value to display
//  nibble       out  4           hex digit to decoder; integrator zero-extends to decoder's 32-bit input
//  digit_sel    out  NUM_DIGITS  digit enables, active-low, at most one bit low
//  frame_done   out  1           one-cycle pulse after each frame boundary
//  pending      out  1           high while a written value awaits the next frame boundary
// BEHAVIOUR
//  - Reset (sync, clk edge with rst=1):
//    - digit_sel = all 1; nibble = 0; frame_done = 0; pending = 0.
//    - Display register, pending register, slot index and cycle count all cleared; FSM enters BLANK.
//  - rst overrides everything, including a write in the same cycle, and aborts a frame mid-slot.
//  - FSM, two states; cnt counts 0..SLOT_CYCLES-1 within a slot, idx counts 0..NUM_DIGITS-1:
//    - BLANK:
//      - Runs for cnt 0..BLANK_CYCLES-1, with digit_sel = all 1.
//      - Moves to DRIVE on the edge where cnt reaches BLANK_CYCLES.
//    - DRIVE:
//      - Runs for cnt BLANK_CYCLES..SLOT_CYCLES-1.
//      - Drives digit_sel[idx] = 0 (others 1) and nibble = disp[4*idx+3:4*idx].
//      - On cnt = SLOT_CYCLES-1: cnt <= 0, idx <= idx+1 (wraps NUM_DIGITS-1 -> 0), FSM -> BLANK.
//  - All outputs are registered: they take their new value on the same edge the FSM enters the state.
//  - nibble holds its last value during BLANK (don't-care, but must be stable).
//  - Frame boundary: the DRIVE->BLANK edge where idx wraps to 0.
//    - If pending = 1: disp <= pending value; pending <= 0.
//    - frame_done = 1 for exactly the one cycle following this edge.
//  - Writes:
//    - wr_en outside a boundary edge: pending value <= wr_data; pending <= 1.
//    - Multiple writes within one frame: last write wins.
//    - wr_en on the boundary edge: disp <= wr_data directly (bypass); pending <= 0; any older pending value is dropped.
//  - Worst-case latency write -> visible: one full frame, i.e. NUM_DIGITS*SLOT_CYCLES cycles, plus BLANK_CYCLES.
//  - NUM_DIGITS = 1: every slot end is a frame boundary.
// CONFIGURATION
//  SS_LZB_EN defined (leading-zero blanking):
//    - In DRIVE, a digit idx>0 whose nibble and all higher nibbles (up to NUM_DIGITS-1) are 0 keeps digit_sel = all 1.
//    - Digit 0 is always shown. Slot timing is unchanged.
//  SS_LZB_EN undefined: every digit is driven in its slot, zeros included.
// TESTING  (bench: NUM_DIGITS=8, SLOT_CYCLES=8, BLANK_CYCLES=2 -> 64-cycle frame)
//  1. Reset: rst high 3 cycles -> digit_sel=8'hFF, nibble=0, frame_done=0, pending=0. Then:
//     - first DRIVE edge at cycle 2 after release, digit_sel=8'hFE, nibble=0.
//  2. wr_data=32'h1234ABCD mid-frame -> pending=1 until the boundary.
//     - Next frame shows nibbles D,C,B,A,4,3,2,1 on digit_sel FE,FD,...,7F.
//     - Each digit is low for 6 cycles, with 2 all-FF cycles between digits.
//  3. Writes of 32'h11111111 then 32'h22222222 in one frame -> the next frame shows only 2s.
//     - The 1s never appear; frame_done pulses once per 64 cycles.
//  4. wr_en with 32'hDEADBEEF exactly on the boundary edge -> that frame shows it.
//     - pending stays 0; no older pending value appears.
//  5. rst asserted during the DRIVE of digit 5 -> next cycle all outputs at reset values.
//     - Display shows 0s, i.e. nibble 0 on every digit, until a new write reaches a boundary.
//  6. SS_LZB_EN defined, value 32'h000000A0:
//     - Only digits 0 (nibble 0) and 1 (nibble A) go low.
//     - digit_sel stays 8'hFF in slots 2..7.
//     - Without the macro, all 8 digits are driven.

Source files
------------

// File: rtl/ss_scan_ctrl.sv
// ss_scan_ctrl: time-multiplexed seven-segment scan controller.
// Scans NUM_DIGITS digit slots per frame. Each slot starts with a blanking gap,
// followed by a drive window for one digit. Writes are held in a pending
// register and applied at the frame boundary, so one frame never shows two
// different values.
// Optional build macro: SS_LZB_EN enables leading-zero blanking. When it is
// defined, a digit above digit 0 stays dark if it and every higher digit are 0.
module ss_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  output logic [3:0]            nibble,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic [IDX_W-1:0]        idx, idx_nx;
  logic [31:0]             disp, pend_val;
  logic [NUM_DIGITS-1:0]   sel_nx, drive_sel, one_hot;
  logic [3:0]              nibble_nx;
  logic [31:0]             disp_sh;
  logic                    boundary;

  // Shift the current digit to the bottom and build its active-low enable.
  assign disp_sh = disp >> {idx, 2'b00};
  assign one_hot = ~(NUM_DIGITS'(1) << idx);

`ifdef SS_LZB_EN
  localparam logic [31:0] DIG_MASK = (NUM_DIGITS >= 8) ? 32'hFFFF_FFFF
                                   : 32'((64'd1 << (4*NUM_DIGITS)) - 64'd1);
  logic [31:0] upper;
  logic        hide;
  // Keep a digit dark when it and all higher digits are zero. Digit 0 always shows.
  always_comb begin
    upper     = (disp & DIG_MASK) >> {idx, 2'b00};
    hide      = (idx != '0) && (upper == 32'd0);
    drive_sel = hide ? '1 : one_hot;
  end
`else
  assign drive_sel = one_hot;
`endif

  // Next-state, slot and digit sequencing, and registered output values.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + CNT_W'(1);
    idx_nx    = idx;
    sel_nx    = digit_sel;
    nibble_nx = nibble;
    boundary  = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nx  = DRIVE;
          sel_nx    = drive_sel;
          nibble_nx = disp_sh[3:0];
        end
      end
      DRIVE: begin
        if (cnt == CNT_LAST) begin
          state_nx = BLANK;
          cnt_nx   = '0;
          sel_nx   = '1;
          boundary = (idx == IDX_LAST);
          idx_nx   = boundary ? '0 : idx + IDX_W'(1);
        end
      end
      default: state_nx = BLANK;
    endcase
  end

  // State register and registered scan outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      digit_sel  <= '1;
      nibble     <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      digit_sel  <= sel_nx;
      nibble     <= nibble_nx;
      frame_done <= boundary;
    end
  end

  // Display and pending registers. A write that lands on the boundary edge
  // goes straight to the display and drops any older pending value.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp     <= '0;
      pend_val <= '0;
      pending  <= 1'b0;
    end else if (boundary && wr_en) begin
      disp    <= wr_data;
      pending <= 1'b0;
    end else if (boundary) begin
      if (pending) disp <= pend_val;
      pending <= 1'b0;
    end else if (wr_en) begin
      pend_val <= wr_data;
      pending  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ss_scan_ctrl.sv
// Directed bench for ss_scan_ctrl with 8 digits, 8-cycle slots and 2 blank cycles.
// e counts clock edges since the last reset release. Outputs are sampled on the negedge.
module tb_ss_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [3:0]  nibble;
  logic [7:0]  digit_sel;
  logic        frame_done;
  logic        pending;

  int total = 0;
  int bad   = 0;
  int e     = 0;

  ss_scan_ctrl #(.NUM_DIGITS(8), .SLOT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .nibble(nibble), .digit_sel(digit_sel), .frame_done(frame_done), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    e++;
  endtask

  task automatic go(input int t);
    while (e < t) step();
  endtask

  function automatic logic [7:0] sel_of(input int k);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << k);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (digit_sel !== 8'hFF) begin bad++; $display("FAIL rst_sel: got %h want ff", digit_sel); end
    total++; if (nibble !== 4'h0) begin bad++; $display("FAIL rst_nib: got %h want 0", nibble); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_fd: got %b want 0", frame_done); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL rst_pend: got %b want 0", pending); end
    rst = 1'b0;
    e = 0;
    go(1);
    total++; if (digit_sel !== 8'hFF) begin bad++; $display("FAIL blank1_sel: got %h want ff", digit_sel); end
    go(2);
    total++; if (digit_sel !== 8'hFE) begin bad++; $display("FAIL drive1_sel: got %h want fe", digit_sel); end
    total++; if (nibble !== 4'h0) begin bad++; $display("FAIL drive1_nib: got %h want 0", nibble); end
  endtask

  task automatic test_write();
    logic [3:0] exp [8];
    exp = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};
    wr_data = 32'h1234ABCD; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL wr_pend: got %b want 1", pending); end
    go(63);
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL wr_pend_hold: got %b want 1", pending); end
    total++; if (digit_sel !== 8'h7F) begin bad++; $display("FAIL wr_old_sel: got %h want 7f", digit_sel); end
    total++; if (nibble !== 4'h0) begin bad++; $display("FAIL wr_old_nib: got %h want 0", nibble); end
    go(64);
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL wr_fd: got %b want 1", frame_done); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL wr_pend_clr: got %b want 0", pending); end
    total++; if (digit_sel !== 8'hFF) begin bad++; $display("FAIL wr_bnd_sel: got %h want ff", digit_sel); end
    go(65);
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL wr_fd_pulse: got %b want 0", frame_done); end
    for (int k = 0; k < 8; k++) begin
      go(64 + 8*k + 2);
      total++; if (digit_sel !== sel_of(k)) begin bad++; $display("FAIL wr_sel%0d: got %h want %h", k, digit_sel, sel_of(k)); end
      total++; if (nibble !== exp[k]) begin bad++; $display("FAIL wr_nib%0d: got %h want %h", k, nibble, exp[k]); end
      go(64 + 8*k + 7);
      total++; if (digit_sel !== sel_of(k)) begin bad++; $display("FAIL wr_hold%0d: got %h want %h", k, digit_sel, sel_of(k)); end
      go(64 + 8*k + 8);
      total++; if (digit_sel !== 8'hFF) begin bad++; $display("FAIL wr_gap%0d: got %h want ff", k, digit_sel); end
    end
  endtask

  task automatic test_last_wins();
    int pulses = 0, wrong = 0, driven = 0;
    go(130);
    wr_data = 32'h11111111; wr_en = 1'b1; step();
    wr_data = 32'h22222222; step();
    wr_en = 1'b0;
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL lw_pend: got %b want 1", pending); end
    go(192);
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL lw_fd: got %b want 1", frame_done); end
    for (int i = 193; i <= 256; i++) begin
      step();
      if (frame_done === 1'b1) pulses++;
      if (digit_sel !== 8'hFF) begin
        driven++;
        if (nibble !== 4'h2) wrong++;
      end
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL lw_pulses: got %0d want 1", pulses); end
    total++; if (wrong != 0) begin bad++; $display("FAIL lw_non2: got %0d want 0", wrong); end
    total++; if (driven != 48) begin bad++; $display("FAIL lw_driven: got %0d want 48", driven); end
  endtask

  task automatic test_bypass();
    logic [3:0] exp [8];
    exp = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD};
    go(300);
    wr_data = 32'h55555555; wr_en = 1'b1; step();
    wr_en = 1'b0;
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL bp_old_pend: got %b want 1", pending); end
    go(319);
    wr_data = 32'hDEADBEEF; wr_en = 1'b1; step();
    wr_en = 1'b0;
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL bp_pend: got %b want 0", pending); end
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL bp_fd: got %b want 1", frame_done); end
    for (int k = 0; k < 8; k++) begin
      go(320 + 8*k + 2);
      total++; if (digit_sel !== sel_of(k)) begin bad++; $display("FAIL bp_sel%0d: got %h want %h", k, digit_sel, sel_of(k)); end
      total++; if (nibble !== exp[k]) begin bad++; $display("FAIL bp_nib%0d: got %h want %h", k, nibble, exp[k]); end
    end
    go(385);
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL bp_pend_after: got %b want 0", pending); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL bp_fd_after: got %b want 0", frame_done); end
  endtask

  task automatic test_reset_mid();
    go(400);
    wr_data = 32'h77777777; wr_en = 1'b1; step();
    wr_en = 1'b0;
    go(427);
    total++; if (digit_sel !== 8'hDF) begin bad++; $display("FAIL rm_pre_sel: got %h want df", digit_sel); end
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL rm_pre_pend: got %b want 1", pending); end
    rst = 1'b1; step();
    total++; if (digit_sel !== 8'hFF) begin bad++; $display("FAIL rm_sel: got %h want ff", digit_sel); end
    total++; if (nibble !== 4'h0) begin bad++; $display("FAIL rm_nib: got %h want 0", nibble); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rm_fd: got %b want 0", frame_done); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL rm_pend: got %b want 0", pending); end
    rst = 1'b0;
    e = 0;
    for (int k = 0; k < 8; k++) begin
      go(8*k + 2);
      total++; if (digit_sel !== sel_of(k)) begin bad++; $display("FAIL rm_sel%0d: got %h want %h", k, digit_sel, sel_of(k)); end
      total++; if (nibble !== 4'h0) begin bad++; $display("FAIL rm_nib%0d: got %h want 0", k, nibble); end
    end
    go(64);
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL rm_fd1: got %b want 1", frame_done); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL rm_pend1: got %b want 0", pending); end
    go(66);
    total++; if (nibble !== 4'h0) begin bad++; $display("FAIL rm_nib_next: got %h want 0", nibble); end
  endtask

  task automatic test_lzb();
    logic [7:0] want_sel;
    logic [3:0] want_nib;
    wr_data = 32'h000000A0; wr_en = 1'b1; step();
    wr_en = 1'b0;
    go(128);
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL lz_fd: got %b want 1", frame_done); end
    for (int k = 0; k < 8; k++) begin
      go(128 + 8*k + 2);
`ifdef SS_LZB_EN
      want_sel = (k < 2) ? sel_of(k) : 8'hFF;
`else
      want_sel = sel_of(k);
`endif
      want_nib = (k == 1) ? 4'hA : 4'h0;
      total++; if (digit_sel !== want_sel) begin bad++; $display("FAIL lz_sel%0d: got %h want %h", k, digit_sel, want_sel); end
      if (k < 2 || want_sel != 8'hFF) begin
        total++; if (nibble !== want_nib) begin bad++; $display("FAIL lz_nib%0d: got %h want %h", k, nibble, want_nib); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_last_wins();
    test_bypass();
    test_reset_mid();
    test_lzb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
